// File: rtl/cci_mpf_prim_fifo_rr_drain.sv
// cci_mpf_prim_fifo_rr_drain
// Round-robin drain of N_CHANNELS source FIFOs into one registered output
// stream. Each channel may take up to MAX_BURST consecutive grants.
// Grants stop while the downstream raises almostFull.
//
// Optional feature macro: CCI_MPF_FIFO_RR_DRAIN_PRIO0_EN
//   When defined, channel 0 has strict priority over all others. Channel 0
//   grants leave the round-robin state untouched. The rotation among
//   channels 1..N-1 then resumes exactly where it stopped.

module cci_mpf_prim_fifo_rr_drain #(
    parameter int N_CHANNELS  = 4,
    parameter int N_DATA_BITS = 32,
    parameter int MAX_BURST   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_CHANNELS-1:0]             fifo_notEmpty,
    input  logic [N_CHANNELS*N_DATA_BITS-1:0] fifo_first,
    output logic [N_CHANNELS-1:0]             fifo_deq,
    input  logic                              out_almostFull,
    output logic                              out_valid,
    output logic [N_DATA_BITS-1:0]            out_data,
    output logic [$clog2(N_CHANNELS)-1:0]     out_chan
);

    localparam int CW = $clog2(N_CHANNELS);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [CW-1:0] LAST_CHAN  = CW'(N_CHANNELS - 1);

    // Round-robin state. ownerValid_q marks that a real grant has happened
    // since reset. Without it, the reset value of lastGrant_q (N-1) would win
    // a HOLD on the first grant. Instead, the first grant searches upward
    // from channel 0.
    logic [CW-1:0] lastGrant_q, lastGrant_d;
    logic [BW-1:0] burstCnt_q,  burstCnt_d;
    logic          ownerValid_q, ownerValid_d;

    logic                   outValid_q;
    logic [N_DATA_BITS-1:0] outData_q;
    logic [CW-1:0]          outChan_q;

    logic          grantEn;
    logic          grantAny;
    logic [CW-1:0] grantIdx;
    logic          holdOk;
    logic          prioHit;
    logic          rotFound;
    logic [CW-1:0] rotIdx;

    assign grantEn = !reset && !out_almostFull && (|fifo_notEmpty);

    // Find the first non-empty channel after lastGrant_q, wrapping around and ending on lastGrant_q itself.
    always_comb begin : rotSearch
        int cand;
        cand     = 0;
        rotFound = 1'b0;
        rotIdx   = '0;
        for (int k = 1; k <= N_CHANNELS; k++) begin
            cand = (int'(lastGrant_q) + k) % N_CHANNELS;
`ifdef CCI_MPF_FIFO_RR_DRAIN_PRIO0_EN
            if (cand != 0 && !rotFound && fifo_notEmpty[cand]) begin
                rotFound = 1'b1;
                rotIdx   = CW'(cand);
            end
`else
            if (!rotFound && fifo_notEmpty[cand]) begin
                rotFound = 1'b1;
                rotIdx   = CW'(cand);
            end
`endif
        end
    end

    // Choose this cycle's grant: strict channel 0 (optional), then HOLD, then ROTATE.
    always_comb begin
        grantAny     = 1'b0;
        grantIdx     = lastGrant_q;
        lastGrant_d  = lastGrant_q;
        burstCnt_d   = burstCnt_q;
        ownerValid_d = ownerValid_q;
        fifo_deq     = '0;
        prioHit      = 1'b0;
`ifdef CCI_MPF_FIFO_RR_DRAIN_PRIO0_EN
        prioHit      = fifo_notEmpty[0];
`endif
        holdOk = ownerValid_q && fifo_notEmpty[lastGrant_q] && (burstCnt_q < BURST_LAST);

        if (grantEn) begin
            if (prioHit) begin
                grantAny = 1'b1;
                grantIdx = '0;
            end else if (holdOk) begin
                grantAny   = 1'b1;
                grantIdx   = lastGrant_q;
                burstCnt_d = burstCnt_q + BW'(1);
            end else if (rotFound) begin
                grantAny     = 1'b1;
                grantIdx     = rotIdx;
                lastGrant_d  = rotIdx;
                burstCnt_d   = '0;
                ownerValid_d = 1'b1;
            end
        end

        if (grantAny) begin
            fifo_deq[grantIdx] = 1'b1;
        end
    end

    // Scheduler state register. It only changes on a grant, so stalls resume the burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant_q  <= LAST_CHAN;
            burstCnt_q   <= '0;
            ownerValid_q <= 1'b0;
        end else begin
            lastGrant_q  <= lastGrant_d;
            burstCnt_q   <= burstCnt_d;
            ownerValid_q <= ownerValid_d;
        end
    end

    // Output valid goes high exactly one cycle after a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            outValid_q <= 1'b0;
        end else begin
            outValid_q <= grantAny;
        end
    end

    // Capture the granted head entry and its channel index. No reset is needed because valid qualifies these.
    always_ff @(posedge clk) begin
        if (grantAny) begin
            outData_q <= fifo_first[grantIdx*N_DATA_BITS +: N_DATA_BITS];
            outChan_q <= grantIdx;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_chan  = outChan_q;

`ifndef SYNTHESIS
    // Guard the source FIFOs: never dequeue an empty channel, and never dequeue more than one channel at once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ((fifo_deq & ~fifo_notEmpty) == '0)
                else $fatal(1, "fifo_deq set on an empty channel: deq=%b notEmpty=%b", fifo_deq, fifo_notEmpty);
            assert ($onehot0(fifo_deq))
                else $fatal(1, "fifo_deq not one-hot: %b", fifo_deq);
        end
    end
`endif

endmodule

// File: tb/tb_cci_mpf_prim_fifo_rr_drain.sv
// Testbench for cci_mpf_prim_fifo_rr_drain.
// The source FIFOs are modelled as queues. Their notEmpty is driven from the
// queue occupancy on each negative edge, so a dequeue becomes visible the
// following cycle, just like a registered notEmpty.
// The scheduler reference model works directly from the grant rules: strict
// channel 0 when enabled, then hold, then rotate.

module tb_cci_mpf_prim_fifo_rr_drain;

    localparam int N  = 4;
    localparam int D  = 32;
    localparam int MB = 4;
    localparam int CW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     fifo_notEmpty;
    logic [N*D-1:0]   fifo_first;
    logic [N-1:0]     fifo_deq;
    logic             out_almostFull;
    logic             out_valid;
    logic [D-1:0]     out_data;
    logic [CW-1:0]    out_chan;

    cci_mpf_prim_fifo_rr_drain #(
        .N_CHANNELS (N),
        .N_DATA_BITS(D),
        .MAX_BURST  (MB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_notEmpty (fifo_notEmpty),
        .fifo_first    (fifo_first),
        .fifo_deq      (fifo_deq),
        .out_almostFull(out_almostFull),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_chan      (out_chan)
    );

    // Free-running clock with a 10-time-unit period.
    always #5 clk = ~clk;

    logic [D-1:0] fq [N][$];
    int checks   = 0;
    int failures = 0;

    // Reference scheduler state.
    //   mLast  = channel that currently owns the burst
    //   mCnt   = grants already given in this burst, minus one
    //   mOwner = a round-robin grant has happened since the last reset
    int mLast  = N - 1;
    int mCnt   = 0;
    bit mOwner = 1'b0;

    bit            expValid = 1'b0;
    logic [D-1:0]  expData  = '0;
    logic [CW-1:0] expChan  = '0;
    bit            outKnown = 1'b0;
    int            grantLog[$];
    int            gKind;

    // Reference grant decision.
    // Return value: granted channel, or -1 when there is no grant.
    // kind: 1 = hold, 2 = rotate, 3 = strict channel 0.
    function automatic int modelGrant(input bit rst, input bit af, output int kind);
        bit any;
        int c;
        kind = 0;
        any  = 1'b0;
        for (int i = 0; i < N; i++) if (fq[i].size() != 0) any = 1'b1;
        if (rst || af || !any) return -1;
`ifdef CCI_MPF_FIFO_RR_DRAIN_PRIO0_EN
        if (fq[0].size() != 0) begin
            kind = 3;
            return 0;
        end
`endif
        if (mOwner && fq[mLast].size() != 0 && mCnt < MB - 1) begin
            kind = 1;
            return mLast;
        end
        for (int k = 1; k <= N; k++) begin
            c = (mLast + k) % N;
`ifdef CCI_MPF_FIFO_RR_DRAIN_PRIO0_EN
            if (c == 0) continue;
`endif
            if (fq[c].size() != 0) begin
                kind = 2;
                return c;
            end
        end
        return -1;
    endfunction

    function automatic bit allEmpty();
        for (int i = 0; i < N; i++) if (fq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic loadFifo(input int ch, input int n);
        for (int i = 0; i < n; i++) fq[ch].push_back({8'(ch), 24'($urandom)});
    endtask

    // Compare the DUT's dequeue strobe and registered outputs against the model.
    task automatic checkOutput(input int g);
        logic [N-1:0] expDeq;
        int           obs;
        expDeq = '0;
        if (g >= 0) expDeq[g] = 1'b1;
        checks++;
        assert (fifo_deq === expDeq) else begin
            failures++;
            $error("[TB] FAIL deq: observed=%b expected=%b t=%0t", fifo_deq, expDeq, $time);
        end
        if (outKnown) begin
            checks++;
            assert (out_valid === expValid) else begin
                failures++;
                $error("[TB] FAIL valid: observed=%b expected=%b t=%0t", out_valid, expValid, $time);
            end
            if (expValid) begin
                checks++;
                assert (out_data === expData) else begin
                    failures++;
                    $error("[TB] FAIL data: observed=%h expected=%h t=%0t", out_data, expData, $time);
                end
                checks++;
                assert (out_chan === expChan) else begin
                    failures++;
                    $error("[TB] FAIL chan: observed=%0d expected=%0d t=%0t", out_chan, expChan, $time);
                end
            end
        end
        obs = -1;
        for (int c = N - 1; c >= 0; c--) if (fifo_deq[c] === 1'b1) obs = c;
        if (obs >= 0) grantLog.push_back(obs);
    endtask

    // Run one clock cycle.
    //   1. Drive inputs on the falling edge.
    //   2. Check just afterwards.
    //   3. Advance the model at the rising edge.
    task automatic applyStimulus(input bit rst, input bit af);
        int g;
        @(negedge clk);
        reset          = rst;
        out_almostFull = af;
        for (int c = 0; c < N; c++) begin
            fifo_notEmpty[c]     = (fq[c].size() != 0);
            fifo_first[c*D +: D] = (fq[c].size() != 0) ? fq[c][0] : '0;
        end
        #1;
        g = modelGrant(rst, af, gKind);
        checkOutput(g);
        @(posedge clk);
        if (rst) begin
            mLast    = N - 1;
            mCnt     = 0;
            mOwner   = 1'b0;
            expValid = 1'b0;
            outKnown = 1'b1;
        end else if (g >= 0) begin
            expValid = 1'b1;
            expData  = fq[g][0];
            expChan  = CW'(g);
            void'(fq[g].pop_front());
            if (gKind == 1) begin
                mCnt++;
            end else if (gKind == 2) begin
                mLast  = g;
                mCnt   = 0;
                mOwner = 1'b1;
            end
        end else begin
            expValid = 1'b0;
        end
    endtask

    // Keep granting until every source FIFO is empty (bounded), then idle for a couple of cycles.
    task automatic drainAll(input string tag);
        for (int i = 0; i < 300 && !allEmpty(); i++) applyStimulus(1'b0, 1'b0);
        checks++;
        assert (allEmpty()) else begin
            failures++;
            $error("[TB] FAIL %s_drain: observed=not_empty expected=empty", tag);
        end
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    // Directed scenarios first, then a randomized soak, then the summary line.
    initial begin
        reset          = 1'b1;
        out_almostFull = 1'b0;
        fifo_notEmpty  = '0;
        fifo_first     = '0;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);

        $display("[TB] all four channels full, burst rotation");
        for (int c = 0; c < N; c++) loadFifo(c, 8);
        grantLog.delete();
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
`ifndef CCI_MPF_FIFO_RR_DRAIN_PRIO0_EN
        checks++;
        assert (grantLog.size() == 20) else begin
            failures++;
            $error("[TB] FAIL rr_count: observed=%0d expected=20", grantLog.size());
        end
        for (int i = 0; i < 20; i++) begin
            if (i < grantLog.size()) begin
                checks++;
                assert (grantLog[i] == (i / MB) % N) else begin
                    failures++;
                    $error("[TB] FAIL rr_seq[%0d]: observed=%0d expected=%0d", i, grantLog[i], (i / MB) % N);
                end
            end
        end
`endif
        drainAll("full");

        $display("[TB] single channel self-rotate");
        loadFifo(2, 10);
        drainAll("single");

        $display("[TB] uneven occupancy");
        loadFifo(1, 2);
        loadFifo(3, 5);
        drainAll("uneven");

        $display("[TB] stall mid-burst");
        applyStimulus(1'b1, 1'b0);
        loadFifo(0, 6);
        loadFifo(1, 2);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
        drainAll("stall");

        $display("[TB] reset mid-burst");
        loadFifo(1, 6);
        loadFifo(2, 3);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        drainAll("midreset");

`ifdef CCI_MPF_FIFO_RR_DRAIN_PRIO0_EN
        $display("[TB] channel 0 priority pre-emption");
        loadFifo(2, 6);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        loadFifo(0, 3);
        drainAll("prio0");
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 2) == 0) loadFifo(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 3)));
            applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0);
        end
        drainAll("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net in case a wait never completes.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
